// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the MIPS1000 memory-port arbiter: the sequencer
// state encoding and the default wait-state / burst constants that the
// memory controller and cache models also rely on.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // Sequencer states (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_BURST   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Default transaction timing
    localparam int unsigned DEF_BURST_COUNT = 4;
    localparam int unsigned DEF_RD_WAIT     = 2;
    localparam int unsigned DEF_WR_WAIT     = 1;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The request vector is rotated so the
// requester after ptr sits at bit 0, a fixed-priority (lowest bit first)
// select is applied, and the result is rotated back to a real index.
//
// Ports:
//   request        in   N      request vector
//   ptr            in   IDX_W  index of the last requester served
//   winner_onehot  out  N      one-hot winner, zero when no request
//   winner_idx     out  IDX_W  binary index of the winner
//   found          out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    int unsigned      start;
    int unsigned      pos;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] src;

    always_comb begin
        start = (32'(ptr) + 1) % N;
        src   = '0;

        // Rotate: rotated[j] is the requester j places after ptr
        rotated = '0;
        for (int j = 0; j < N; j++) begin
            src        = IDX_W'((start + j) % N);
            rotated[j] = request[src];
        end

        // Fixed-priority select on the rotated vector
        found = 1'b0;
        pos   = 0;
        for (int j = 0; j < N; j++) begin
            if (rotated[j] && !found) begin
                found = 1'b1;
                pos   = j;
            end
        end

        // Rotate back
        winner_idx                = IDX_W'((start + pos) % N);
        winner_onehot             = '0;
        winner_onehot[winner_idx] = found;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Round-robin arbiter and burst sequencer for the shared memory port.
// Grants one requester per transaction, inserts read/write dependent wait
// states, runs a fixed-length burst, then spends one turnaround cycle
// before arbitrating again. The priority pointer only advances when a
// burst completes, so an aborted grant does not cost anyone their turn.
//
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous active-high reset
//   read_request   in   N      per-requester read request (level)
//   write_request  in   N      per-requester write request (level)
//   grant          out  N      registered one-hot grant, zero when idle
//   rwbar          out  1      1 = read, 0 = write, valid while grant != 0
//   ready          out  1      one pulse per data beat
//   memory_sel     out  1      chip select, high during burst beats
//   beat           out  CNT_W  beat index within the burst, 0 otherwise
//   busy           out  1      sequencer not idle
// ---------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned BURST_COUNT = DEF_BURST_COUNT,
    parameter int unsigned RD_WAIT     = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT     = DEF_WR_WAIT,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     read_request,
    input  logic [N-1:0]     write_request,
    output logic [N-1:0]     grant,
    output logic             rwbar,
    output logic             ready,
    output logic             memory_sel,
    output logic [CNT_W-1:0] beat,
    output logic             busy
);

    localparam int unsigned      IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] RD_CNT    = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT    = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             rwbar_q, rwbar_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;

    logic [N-1:0]     request;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    assign request = read_request | write_request;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .request       (request),
        .ptr           (ptr_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .found         (pick_found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rwbar_d = rwbar_q;
        ready_d = ready_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_WAIT;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    // Read wins when a requester asks for both
                    rwbar_d = read_request[pick_idx];
                    wait_d  = read_request[pick_idx] ? RD_CNT : WR_CNT;
                end
            end
            ST_WAIT: begin
                if (!request[gidx_q]) begin
                    // Requester withdrew before the burst: drop it, keep ptr
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rwbar_d = 1'b0;
                    wait_d  = '0;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    state_d = ST_BURST;
                    ready_d = 1'b1;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                // Request deassertion is ignored once the burst has started
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_RELEASE;
                    ready_d = 1'b0;
                    beat_d  = '0;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Bus turnaround, no arbitration this cycle
                state_d = ST_IDLE;
                rwbar_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rwbar_q <= 1'b0;
            ready_q <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
            ptr_q   <= PTR_INIT;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rwbar_q <= rwbar_d;
            ready_q <= ready_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    assign grant      = grant_q;
    assign rwbar      = rwbar_q;
    assign ready      = ready_q;
    assign memory_sel = ready_q;
    assign beat       = beat_q;
    assign busy       = (state_q != ST_IDLE);

    grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Directed scenarios with cycle-by-cycle expectations, then a randomized
// phase where the driver pushes predicted transactions into a queue and a
// negedge monitor pops and compares each transaction the DUT performs.
// ---------------------------------------------------------------------------
module tb_mem_rr_arbiter;

    localparam int N     = 4;
    localparam int BC    = 4;
    localparam int RDW   = 2;
    localparam int WRW   = 1;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     read_request;
    logic [N-1:0]     write_request;
    logic [N-1:0]     grant;
    logic             rwbar;
    logic             ready;
    logic             memory_sel;
    logic [CNT_W-1:0] beat;
    logic             busy;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .N           (N),
        .BURST_COUNT (BC),
        .RD_WAIT     (RDW),
        .WR_WAIT     (WRW),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read_request  (read_request),
        .write_request (write_request),
        .grant         (grant),
        .rwbar         (rwbar),
        .ready         (ready),
        .memory_sel    (memory_sel),
        .beat          (beat),
        .busy          (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0] g;
        logic         rw;
        int           w;
        bit           abort;
    } exp_t;

    exp_t exp_q[$];

    // First requester after ptr, searching cyclically
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int s = 1; s <= N; s++) begin
            int i = (ptr + s) % N;
            if (((req >> i) & N'(1)) != 0) return i;
        end
        return -1;
    endfunction

    // ---------------- monitor ----------------
    bit           mon_en = 0;
    bit           in_txn = 0;
    int           stray  = 0;
    logic [N-1:0] cap_g;
    logic         cap_rw;
    int           cyc, first_rdy, beats, bad_beat, bad_sel, bad_hold;

    task automatic end_txn();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("sb_grant", int'(cap_g), int'(e.g));
        check("sb_rwbar", int'(cap_rw), int'(e.rw));
        if (e.abort) begin
            check("sb_abort_beats", beats, 0);
        end else begin
            check("sb_first_ready", first_rdy, e.w + 1);
            check("sb_beats", beats, BC);
        end
        check("sb_beat_idx", bad_beat, 0);
        check("sb_memsel", bad_sel, 0);
        check("sb_hold", bad_hold, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (grant == '0 && (ready || memory_sel)) stray++;
            if (grant != '0) begin
                if (!in_txn) begin
                    in_txn    = 1;
                    cap_g     = grant;
                    cap_rw    = rwbar;
                    cyc       = 0;
                    first_rdy = -1;
                    beats     = 0;
                    bad_beat  = 0;
                    bad_sel   = 0;
                    bad_hold  = 0;
                end else begin
                    cyc++;
                end
                if (grant != cap_g || rwbar != cap_rw) bad_hold++;
                if (memory_sel != ready) bad_sel++;
                if (ready) begin
                    if (first_rdy < 0) first_rdy = cyc;
                    if (int'(beat) != beats) bad_beat++;
                    beats++;
                end else if (beat != '0) begin
                    bad_beat++;
                end
            end else if (in_txn) begin
                in_txn = 0;
                end_txn();
            end
        end
    end

    // ---------------- directed helper ----------------
    // Called between a negedge and the next posedge; checks the whole
    // transaction after edges 0 .. W+BC+2 relative to the arbitration edge.
    task automatic run_single(input string lbl, input logic [N-1:0] rd, input logic [N-1:0] wr,
                              input int idx, input bit keep);
        logic [N-1:0] g;
        logic         rw;
        int           w;
        bit           er;
        g  = N'(1) << idx;
        rw = |(rd & g);
        w  = rw ? RDW : WRW;
        read_request  = rd;
        write_request = wr;
        for (int t = 0; t <= w + BC + 2; t++) begin
            @(negedge clk);
            er = (t >= w + 1) && (t <= w + BC);
            check($sformatf("%s grant t%0d", lbl, t), int'(grant), (t <= w + BC) ? int'(g) : 0);
            check($sformatf("%s ready t%0d", lbl, t), int'(ready), int'(er));
            check($sformatf("%s msel t%0d", lbl, t), int'(memory_sel), int'(er));
            check($sformatf("%s beat t%0d", lbl, t), int'(beat), er ? t - w - 1 : 0);
            check($sformatf("%s busy t%0d", lbl, t), int'(busy), int'(t <= w + BC + 1));
            if (t <= w + BC) check($sformatf("%s rwbar t%0d", lbl, t), int'(rwbar), int'(rw));
        end
        if (!keep) begin
            read_request  = '0;
            write_request = '0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] pend_rd, pend_wr, bitv;
        int           model_ptr, win, ty;
        exp_t         e;

        rst           = 1'b1;
        read_request  = '0;
        write_request = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset grant", int'(grant), 0);
        check("reset rwbar", int'(rwbar), 0);
        check("reset ready", int'(ready), 0);
        check("reset msel", int'(memory_sel), 0);
        check("reset beat", int'(beat), 0);
        check("reset busy", int'(busy), 0);

        run_single("rd0", 4'b0001, 4'b0000, 0, 0);
        run_single("wr2", 4'b0000, 4'b0100, 2, 0);
        run_single("rw1", 4'b0010, 4'b0010, 1, 0);
        run_single("w1", 4'b0000, 4'b0010, 1, 0);
        run_single("rr3", 4'b1001, 4'b0000, 3, 0);

        // Fairness: all requesters held, pointer at 3
        for (int n = 0; n < 5; n++)
            run_single($sformatf("fair%0d", n), 4'b1111, 4'b0000, n % N, n == 4);

        // Abort in WAIT on requester 3; pointer must stay at 0
        read_request = 4'b1000;
        @(negedge clk);
        check("abort grant", int'(grant), 8);
        read_request = '0;
        @(negedge clk);
        check("abort grant0", int'(grant), 0);
        check("abort busy", int'(busy), 0);
        check("abort ready", int'(ready), 0);
        @(negedge clk);
        check("abort msel", int'(memory_sel), 0);
        run_single("post_abort", 4'b1001, 4'b0000, 3, 0);
        run_single("pre_rst", 4'b0001, 4'b0000, 0, 0);

        // Async reset in the middle of a burst
        read_request = 4'b0010;
        repeat (6) @(negedge clk);
        check("mid beat", int'(beat), 2);
        #2 rst = 1'b1;
        #1;
        check("async grant", int'(grant), 0);
        check("async ready", int'(ready), 0);
        check("async msel", int'(memory_sel), 0);
        check("async beat", int'(beat), 0);
        check("async busy", int'(busy), 0);
        read_request = '0;
        @(negedge clk);
        rst = 1'b0;
        run_single("post_rst", 4'b0101, 4'b0000, 0, 0);

        // ---------------- randomized scoreboard phase ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        model_ptr = N - 1;
        pend_rd   = '0;
        pend_wr   = '0;
        mon_en    = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                bitv = N'(1) << i;
                if (((pend_rd | pend_wr) & bitv) == 0 && $urandom_range(0, 2) == 0) begin
                    ty = $urandom_range(1, 3);
                    if (ty & 1) pend_rd |= bitv;
                    if (ty & 2) pend_wr |= bitv;
                end
            end
            if ((pend_rd | pend_wr) == '0) begin
                bitv = N'(1) << $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 0) pend_rd |= bitv;
                else pend_wr |= bitv;
            end
            read_request  = pend_rd;
            write_request = pend_wr;

            win     = model_pick(pend_rd | pend_wr, model_ptr);
            e.g     = N'(1) << win;
            e.rw    = |(pend_rd & e.g);
            e.w     = e.rw ? RDW : WRW;
            e.abort = ($urandom_range(0, 4) == 0);
            exp_q.push_back(e);

            @(posedge clk);
            if (e.abort) begin
                @(negedge clk);
                pend_rd &= ~e.g;
                pend_wr &= ~e.g;
                read_request  = pend_rd;
                write_request = pend_wr;
                @(posedge clk);
            end else begin
                repeat (e.w + BC + 1) @(posedge clk);
                @(negedge clk);
                pend_rd &= ~e.g;
                pend_wr &= ~e.g;
                read_request  = pend_rd;
                write_request = pend_wr;
                @(posedge clk);
                model_ptr = win;
            end
        end
        @(negedge clk);
        @(negedge clk);
        mon_en = 0;
        check("sb_leftover", exp_q.size(), 0);
        check("sb_stray_ready", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
